sram_frame_scheduler: RTL and testbench

Time-multiplexes the single 16-bit external SRAM between the VGA pixel fetch and the drawing engine, using two 640x480 frame buffers (ping-pong). Each frame start swaps buffers and, optionally, fills the new draw buffer with the background colour before program writes are accepted. The block sits between `vga_controller`/`vga_color_extend` on the read side and the sprite/ball drawing logic on the write side. It drives the SRAM pins directly.

---
 rtl/sram_frame_scheduler.sv | 153 +++++++++++++++
 tb/tb_sram_frame_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_frame_scheduler.sv
// sram_frame_scheduler: ping-pong frame-buffer arbiter sharing one 16-bit SRAM between VGA fetch and drawing
//
// Slot register p alternates every clk: p=0 cycles carry a VGA read, p=1 cycles carry a write
// (background clear or program pixel). Frame starts swap the draw/display buffers.
// Optional feature macro: SRAM_SCHED_CLEAR_EN adds the background-clear phase after each swap.
//
// Ports:
//   clk, reset_n              system clock, asynchronous active-low reset
//   frame_clk                 frame marker, rising edge = frame start (synchronised internally)
//   vga_rd_req, vga_x, vga_y  pixel fetch request from the display buffer
//   vga_data, vga_data_valid  fetched RGB565 pixel and its one-cycle strobe
//   wr_valid, wr_ready        program write handshake carrying wr_x, wr_y, wr_data
//   background_data           clear colour
//   draw_buf                  buffer being drawn (display buffer is ~draw_buf)
//   clearing, frame_overrun   clear phase active, pulse when a frame edge lands mid-clear
//   SRAM_*                    SRAM pins, SRAM_ADDR = {buf, y[8:0], x[9:0]}
module sram_frame_scheduler #(
   parameter int H_RES = 640,
   parameter int V_RES = 480
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        frame_clk,
   input  logic        vga_rd_req,
   input  logic [9:0]  vga_x,
   input  logic [9:0]  vga_y,
   output logic [15:0] vga_data,
   output logic        vga_data_valid,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [9:0]  wr_x,
   input  logic [9:0]  wr_y,
   input  logic [15:0] wr_data,
   input  logic [15:0] background_data,
   output logic        draw_buf,
   output logic        clearing,
   output logic        frame_overrun,
   output logic        SRAM_CE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   output logic [19:0] SRAM_ADDR,
   inout  wire  [15:0] SRAM_DQ
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_DRAW  = 2'd2;
   localparam logic [9:0] H_LIM   = 10'(H_RES);
   localparam logic [9:0] V_LIM   = 10'(V_RES);

   logic        p, fs1, fs2, fs3, pend, we_n, oe_n, ovr_q;
   logic [1:0]  state;
   logic [19:0] addr;
   logic [15:0] dout;
   logic        rise, fe_now, in_range, hs, unused_ok;

   // a synchronised frame rise waits in pend until the next read-slot boundary (p 1->0)
   assign rise      = fs2 & ~fs3;
   assign fe_now    = p & (pend | rise);
   assign in_range  = (wr_x < H_LIM) && (wr_y < V_LIM);
   assign wr_ready  = (state == S_DRAW) && !p;
   assign hs        = wr_valid && wr_ready;
   assign SRAM_CE_N = ~reset_n;
   assign SRAM_UB_N = ~reset_n;
   assign SRAM_LB_N = ~reset_n;
   assign SRAM_OE_N = oe_n;
   assign SRAM_WE_N = we_n;
   assign SRAM_ADDR = addr;
   // DQ is driven only while WE_N is low, and OE_N is always high in that cycle
   assign SRAM_DQ   = we_n ? 16'hzzzz : dout;
   assign frame_overrun = ovr_q;
   assign unused_ok = ^{vga_y[9], background_data};

`ifdef SRAM_SCHED_CLEAR_EN
   logic [9:0] cx;
   logic [8:0] cy;
   logic       last_x, last_y;
   assign last_x   = cx == 10'(H_RES - 1);
   assign last_y   = cy == 9'(V_RES - 1);
   assign clearing = state == S_CLEAR;
`else
   assign clearing = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         p              <= 1'b0;
         fs1            <= 1'b0;
         fs2            <= 1'b0;
         fs3            <= 1'b0;
         pend           <= 1'b0;
         state          <= S_IDLE;
         draw_buf       <= 1'b0;
         we_n           <= 1'b1;
         oe_n           <= 1'b1;
         addr           <= '0;
         dout           <= '0;
         vga_data       <= '0;
         vga_data_valid <= 1'b0;
         ovr_q          <= 1'b0;
`ifdef SRAM_SCHED_CLEAR_EN
         cx             <= '0;
         cy             <= '0;
`endif
      end else begin
         p              <= ~p;
         fs1            <= frame_clk;
         fs2            <= fs1;
         fs3            <= fs2;
         pend           <= !p && (pend || rise);
         vga_data_valid <= 1'b0;
         ovr_q          <= 1'b0;
         if (p) begin
            // read slot: the fetch already targets the display buffer after a swap on this edge
            we_n <= 1'b1;
            oe_n <= !vga_rd_req;
            if (vga_rd_req) addr <= {~(draw_buf ^ fe_now), vga_y[8:0], vga_x};
            if (fe_now) begin
               draw_buf <= ~draw_buf;
`ifdef SRAM_SCHED_CLEAR_EN
               state    <= S_CLEAR;
               cx       <= '0;
               cy       <= '0;
               ovr_q    <= state == S_CLEAR;
`else
               state    <= S_DRAW;
`endif
            end
         end else begin
            // write slot: capture the finished read, then launch this slot's write
            oe_n           <= 1'b1;
            vga_data_valid <= !oe_n;
            if (!oe_n) vga_data <= SRAM_DQ;
`ifdef SRAM_SCHED_CLEAR_EN
            if (state == S_CLEAR) begin
               we_n <= 1'b0;
               addr <= {draw_buf, cy, cx};
               dout <= background_data;
               cx   <= last_x ? 10'd0 : cx + 10'd1;
               if (last_x) cy <= cy + 9'd1;
               if (last_x && last_y) state <= S_DRAW;
            end else
`endif
            // out-of-range coordinates complete the handshake but never reach the SRAM
            if (hs && in_range) begin
               we_n <= 1'b0;
               addr <= {draw_buf, wr_y[8:0], wr_x};
               dout <= wr_data;
            end
         end
      end
endmodule

// File: tb/tb_sram_frame_scheduler.sv
// tb_sram_frame_scheduler: scoreboard bench for sram_frame_scheduler with a behavioural SRAM
module tb_sram_frame_scheduler;
   localparam int H = 16;
   localparam int V = 24;

   logic        clk = 1'b0, reset_n = 1'b0, frame_clk = 1'b0, vga_rd_req = 1'b0, wr_valid = 1'b0;
   logic [9:0]  vga_x = '0, vga_y = '0, wr_x = '0, wr_y = '0;
   logic [15:0] wr_data = '0, background_data = 16'h001F;
   logic [15:0] vga_data;
   logic        vga_data_valid, wr_ready, draw_buf, clearing, frame_overrun;
   logic        ce_n, ub_n, lb_n, oe_n, we_n;
   logic [19:0] sram_addr;
   wire  [15:0] sram_dq;
   logic [15:0] mem [0:1048575];
   logic        pre_en = 1'b0;
   logic [15:0] exp_rd [$];
   logic [35:0] exp_wr [$];
   int          n_cmp = 0, n_fail = 0, ovr_cnt = 0;
   logic        exp_buf = 1'b0, prev_oe_n = 1'b1;

   sram_frame_scheduler #(.H_RES(H), .V_RES(V)) dut (
      .clk(clk), .reset_n(reset_n), .frame_clk(frame_clk),
      .vga_rd_req(vga_rd_req), .vga_x(vga_x), .vga_y(vga_y),
      .vga_data(vga_data), .vga_data_valid(vga_data_valid),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
      .background_data(background_data), .draw_buf(draw_buf), .clearing(clearing),
      .frame_overrun(frame_overrun), .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
      .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq)
   );

   always #5 clk = ~clk;

   assign sram_dq = (!oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;

   always @(posedge clk)
      if (!we_n) mem[sram_addr] <= sram_dq;
      else if (pre_en) mem[{1'b1, 9'd3, 10'd7}] <= 16'hABCD;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // monitor: every read strobe and every WE_N-low cycle must match the next queued expectation
   always @(negedge clk)
      if (reset_n) begin
         if (vga_data_valid) begin
            chk("rd_after_read_slot", 64'(prev_oe_n), 64'd0);
            chk("rd_expected", 64'(exp_rd.size() > 0), 64'd1);
            if (exp_rd.size() > 0) chk("rd_data", 64'(vga_data), 64'(exp_rd.pop_front()));
         end
         if (!we_n) begin
            chk("wr_oe_high", 64'(oe_n), 64'd1);
            chk("wr_expected", 64'(exp_wr.size() > 0), 64'd1);
            if (exp_wr.size() > 0) chk("wr_addr_data", 64'({sram_addr, sram_dq}), 64'(exp_wr.pop_front()));
         end
         if (frame_overrun) ovr_cnt++;
         prev_oe_n = oe_n;
      end

   task automatic push_clear(input logic b, input int n);
      for (int i = 0; i < n; i++)
         exp_wr.push_back({b, 9'(i / H), 10'(i % H), background_data});
   endtask

   task automatic do_read(input logic [9:0] x, input logic [9:0] y, input logic [15:0] d);
      exp_rd.push_back(d);
      vga_x = x;
      vga_y = y;
      vga_rd_req = 1'b1;
      repeat (2) @(negedge clk);
      vga_rd_req = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_write(input logic [9:0] x, input logic [9:0] y, input logic [15:0] d, input logic lands);
      int t = 0;
      while (!wr_ready && t < 10) begin
         @(negedge clk);
         t++;
      end
      chk("wr_ready_slot", 64'(wr_ready), 64'd1);
      if (lands) exp_wr.push_back({exp_buf, y[8:0], x, d});
      wr_x = x;
      wr_y = y;
      wr_data = d;
      wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic frame_edge(output int lat);
      lat = 0;
      frame_clk = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (draw_buf === exp_buf) begin
            lat = i;
            break;
         end
      end
      frame_clk = 1'b0;
   endtask

   task automatic wait_clear_done();
      int t = 0;
      while (clearing && t < 2 * H * V + 40) begin
         @(negedge clk);
         t++;
      end
      chk("clear_done_in_time", 64'(clearing), 64'd0);
      @(negedge clk);
   endtask

   initial begin
      int   lat, n;
      logic seen;
      pre_en = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_strobes", 64'({ce_n, ub_n, lb_n, oe_n, we_n}), 64'h1f);
      chk("rst_addr", 64'(sram_addr), 64'd0);
      chk("rst_outs", 64'({vga_data, vga_data_valid, wr_ready, draw_buf, clearing, frame_overrun}), 64'd0);
      reset_n = 1'b1;
      pre_en = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen |= wr_ready | ~we_n;
      end
      chk("idle_no_write", 64'(seen), 64'd0);
      chk("ce_active", 64'({ce_n, ub_n, lb_n}), 64'd0);
      do_read(10'd7, 10'd3, 16'hABCD);
      chk("rd1_drained", 64'(exp_rd.size()), 64'd0);
      exp_buf = 1'b1;
`ifdef SRAM_SCHED_CLEAR_EN
      push_clear(1'b1, H * V);
`endif
      frame_edge(lat);
      chk("fe1_latency_ok", 64'(lat >= 2 && lat <= 4), 64'd1);
      chk("fe1_draw_buf", 64'(draw_buf), 64'd1);
`ifdef SRAM_SCHED_CLEAR_EN
      chk("fe1_clearing", 64'(clearing), 64'd1);
      wait_clear_done();
      chk("fe1_no_overrun", 64'(ovr_cnt), 64'd0);
      chk("clear1_all_written", 64'(exp_wr.size()), 64'd0);
`else
      chk("fe1_no_clearing", 64'(clearing), 64'd0);
`endif
      seen = 1'b0;
      repeat (2) begin
         @(negedge clk);
         seen |= wr_ready;
      end
      chk("fe1_ready_toggles", 64'(seen), 64'd1);
      do_write(10'd10, 10'd20, 16'hF800, 1'b1);
      do_write(10'd700, 10'd20, 16'h1234, 1'b0);
      do_write(10'd5, 10'd24, 16'h5555, 1'b0);
      do_write(10'd15, 10'd23, 16'h07E0, 1'b1);
      repeat (3) @(negedge clk);
      chk("draw_drained", 64'(exp_wr.size()), 64'd0);
      exp_buf = 1'b0;
`ifdef SRAM_SCHED_CLEAR_EN
      push_clear(1'b0, 6);
`endif
      frame_edge(lat);
      chk("fe2_latency_ok", 64'(lat >= 2 && lat <= 4), 64'd1);
      chk("fe2_draw_buf", 64'(draw_buf), 64'd0);
`ifdef SRAM_SCHED_CLEAR_EN
      chk("fe2_clearing", 64'(clearing), 64'd1);
      n = 0;
      for (int i = 0; i < 40 && n < 5; i++) begin
         @(negedge clk);
         if (!we_n) n++;
      end
      chk("ovr_sync_writes", 64'(n), 64'd5);
      // raised in a write cycle: one more buffer-0 write lands before the swap
      frame_clk = 1'b1;
      exp_buf = 1'b1;
      push_clear(1'b1, H * V);
      repeat (6) @(negedge clk);
      frame_clk = 1'b0;
      chk("ovr_draw_buf", 64'(draw_buf), 64'd1);
      chk("ovr_clearing", 64'(clearing), 64'd1);
      wait_clear_done();
      chk("ovr_pulses", 64'(ovr_cnt), 64'd1);
      chk("ovr_clear_drained", 64'(exp_wr.size()), 64'd0);
      do_read(10'd2, 10'd0, 16'h001F);
      do_read(10'd5, 10'd0, 16'h001F);
`else
      chk("fe2_no_clearing", 64'(clearing), 64'd0);
      chk("fe2_no_overrun", 64'(ovr_cnt), 64'd0);
      do_read(10'd10, 10'd20, 16'hF800);
      do_read(10'd15, 10'd23, 16'h07E0);
`endif
      chk("rd2_drained", 64'(exp_rd.size()), 64'd0);
      do_write(10'd1, 10'd1, 16'hBEEF, 1'b1);
      chk("mw_we_low", 64'(we_n), 64'd0);
      #2 reset_n = 1'b0;
      #1 chk("mw_we_async", 64'({we_n, oe_n, ce_n}), 64'h7);
      @(negedge clk);
      chk("mw_state_cleared", 64'({draw_buf, clearing, wr_ready, vga_data_valid}), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      exp_buf = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen |= wr_ready | ~we_n;
      end
      chk("post_rst_idle", 64'(seen), 64'd0);
      chk("final_wr_drained", 64'(exp_wr.size()), 64'd0);
      chk("final_rd_drained", 64'(exp_rd.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
